sin_nco: RTL and testbench
==========================

// Module: sin_nco
// PURPOSE
//  Numerically controlled oscillator; the read-side client of the quarter-wave sine table (sin_table).
//  Phase accumulator, quadrant folding onto the 256-entry quarter-wave table, sign restoration.
//  Streams signed full-wave samples: DAC path, test-tone generator.
//  Table is external: registered read, 1-cycle latency, entry a = round(255*sin(pi/2*a/255)).
// PARAMETERS
//  PHASE_WIDTH 16  accumulator width; must be >= ADR_WIDTH+2
//  ADR_WIDTH   8   table address width (quarter-wave entries = 2**ADR_WIDTH)
//  DATA_WIDTH  8   unsigned table word width; sample is DATA_WIDTH+1 signed
// PORTS
//  clk          in  1              single clock, all logic on posedge
//  rst_n        in  1              synchronous, active-low reset
//  en           in  1              advance phase and issue one table read this cycle
//  phase_clr    in  1              synchronous clear of phase accumulator to 0
//  phase_inc    in  PHASE_WIDTH    tuning word, unsigned, modulo 2**PHASE_WIDTH
//  tbl_rd       out 1              table read strobe (registered)
//  tbl_addr     out ADR_WIDTH      table address (registered)
//  tbl_data     in  DATA_WIDTH     table read data, valid the cycle after tbl_rd/tbl_addr are sampled
//  sample_out   out DATA_WIDTH+1   signed two's-complement sample, range -(2**DW-1)..+(2**DW-1)
//  sample_valid out 1              one-cycle strobe per new sample
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): phase_acc, tbl_rd, tbl_addr, sample_out, sample_valid, internal pipe regs <= 0.
//    In-flight samples are discarded. tbl_data is not reset by the table; masked by the cleared valid pipe.
//  Phase fields: q = phase_acc[PW-1:PW-2]; idx = phase_acc[PW-3 -: ADR_WIDTH].
//    Lower bits are truncated: no rounding, no dither.
//  Fold: q=0 addr=idx, +; q=1 addr=~idx, +; q=2 addr=idx, -; q=3 addr=~idx, -.
//  Edge e0, phase_clr=1: phase_acc <= 0; tbl_rd <= 0.
//    phase_clr wins over en; no read is issued that cycle.
//  Edge e0, en=1 and phase_clr=0:
//    tbl_addr <= fold(phase_acc); tbl_rd <= 1; neg1 <= q[1];
//    phase_acc <= phase_acc + phase_inc, mod 2**PW.
//  Edge e0, en=0: phase_acc holds; tbl_rd <= 0; tbl_addr holds.
//  Edge e1: table captures data; vld2 <= tbl_rd; neg2 <= neg1.
//  Edge e2: sample_out <= neg2 ? -{1'b0,tbl_data} : {1'b0,tbl_data}; sample_valid <= vld2.
//  Latency: the sample for the phase used at e0 appears after e2.
//    sample_valid trails tbl_rd by exactly 2 edges; with en held high, throughput is 1 sample/clk.
//  When sample_valid=0, sample_out holds its last value. Data 0 in a negative quadrant gives 0.
//  phase_inc is sampled every en cycle; a change takes effect on the next increment, no glitch filtering.
//  Boundaries:
//    q0 idx max and q1 idx 0 both read the top entry (duplicated peak, accepted).
//    The accumulator wraps silently.
//    phase_clr mid-stream does not flush the pipe; up to 2 earlier samples still emerge.
// STRUCTURE
//  Shared package/include sin_pkg: quadrant encodings Q0..Q3, TBL_LATENCY=1, NCO_LATENCY=2, default widths.
//  One sub-module, phase_accumulator: accumulator register, clr/en priority, wrap.
//  Folding, sign pipe and output stage stay in sin_nco.
//  Bench drives tbl_data from a behavioural model.
//    Model: loads sin_table.dat, 1-cycle registered read on tbl_rd.
// TESTING (PW=16, AW=8, DW=8; idx step 1 = 16'h0040)
//  1 Reset: rst_n=0 for 3 clk with en=1 -> tbl_rd=0, sample_valid=0, sample_out=0.
//    After release, first tbl_addr=0.
//  2 Sweep: inc=16'h0040, en=1 for 1024 clk.
//    -> tbl_addr 0..255, 255..0, 0..255, 255..0.
//    -> samples +tbl[0..255], +tbl[255..0], -tbl[0..255], -tbl[255..0].
//    -> sample_valid high from the 3rd edge onward.
//  3 Quadrant hop: inc=16'h4000 -> addr 0,255,0,255...; samples 0,+255,0,-255 repeating.
//  4 Gapped en pattern 1,1,0,1,0,0,1 -> tbl_rd equals en delayed 1 edge; sample_valid equals en delayed 3 edges.
//    Phase advances only on en=1 cycles.
//  5 phase_clr pulse with en=1 while at phase 16'h3000 -> tbl_rd=0 for one cycle.
//    Next tbl_addr=0; the 2 in-flight samples are still emitted.
//  6 Wrap/negative: inc=16'hFFC0 from 0 -> phases 0, FFC0, FF80.
//    -> addr 0,0,1; samples 0, 0, -tbl[1].
//    Also assert rst_n mid-stream -> sample_valid=0 next edge and no stale sample is emitted.

Source files
------------

// File: rtl/sin_pkg.sv
// rtl/sin_pkg.sv - shared quadrant encodings, latencies and default widths for the sine NCO
package sin_pkg;

    localparam int PHASE_WIDTH_DEF = 16;
    localparam int ADR_WIDTH_DEF   = 8;
    localparam int DATA_WIDTH_DEF  = 8;

    // Read latency of the external quarter-wave table (registered read).
    localparam int TBL_LATENCY = 1;
    // Edges between the table read strobe and the output sample strobe.
    localparam int NCO_LATENCY = 2;

    // Quadrant is the top two phase bits.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // Odd quadrants walk the quarter-wave table backwards.
    function automatic logic quad_mirrored(input quadrant_t q);
        return (q == Q1) || (q == Q3);
    endfunction

    // The second half-cycle produces negative samples.
    function automatic logic quad_negative(input quadrant_t q);
        return (q == Q2) || (q == Q3);
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - NCO phase accumulator with clear-over-enable priority and silent wrap
module phase_accumulator #(
    parameter int PHASE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   phase_clr,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    output logic [PHASE_WIDTH-1:0] phase_acc
);

    // Clear beats enable; the add is modulo 2**PHASE_WIDTH so wrap needs no handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_acc <= '0;
        end else if (phase_clr) begin
            phase_acc <= '0;
        end else if (en) begin
            phase_acc <= phase_acc + phase_inc;
        end
    end

endmodule

// File: rtl/sin_nco.sv
// rtl/sin_nco.sv - quarter-wave table NCO: phase fold, table read, sign restore, sample stream
module sin_nco
    import sin_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int ADR_WIDTH   = ADR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         phase_clr,
    input  logic [PHASE_WIDTH-1:0]       phase_inc,
    output logic                         tbl_rd,
    output logic [ADR_WIDTH-1:0]         tbl_addr,
    input  logic [DATA_WIDTH-1:0]        tbl_data,
    output logic signed [DATA_WIDTH:0]   sample_out,
    output logic                         sample_valid
);

    logic [PHASE_WIDTH-1:0] phase_acc;
    quadrant_t              quad;
    logic [ADR_WIDTH-1:0]   idx;
    logic [ADR_WIDTH-1:0]   fold_addr;
    logic                   issue;

    // Sign travels alongside the table read so it lines up with the returned data.
    logic                   neg1;
    logic                   neg2;
    logic                   vld2;

    logic [DATA_WIDTH:0]    mag;
    logic [DATA_WIDTH:0]    signed_val;

    phase_accumulator #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_phase_accumulator (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .phase_inc (phase_inc),
        .phase_acc (phase_acc)
    );

    // Top two bits pick the quadrant; the next ADR_WIDTH bits index the quarter wave,
    // anything below is truncated.
    assign quad  = quadrant_t'(phase_acc[PHASE_WIDTH-1 -: 2]);
    assign idx   = phase_acc[PHASE_WIDTH-3 -: ADR_WIDTH];
    assign issue = en && !phase_clr;

    // Fold the full-wave phase onto the quarter-wave address.
    always_comb begin
        fold_addr = idx;
        if (quad_mirrored(quad)) begin
            fold_addr = ~idx;
        end
    end

    // Issue stage: register the table strobe/address from the pre-increment phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_rd   <= 1'b0;
            tbl_addr <= '0;
            neg1     <= 1'b0;
        end else begin
            tbl_rd <= issue;
            if (issue) begin
                tbl_addr <= fold_addr;
                neg1     <= quad_negative(quad);
            end
        end
    end

    // Table-read stage: track validity and sign while the table produces data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld2 <= 1'b0;
            neg2 <= 1'b0;
        end else begin
            vld2 <= tbl_rd;
            neg2 <= neg1;
        end
    end

    assign mag        = {1'b0, tbl_data};
    assign signed_val = neg2 ? ('0 - mag) : mag;

    // Output stage: restore sign; hold the last sample between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= vld2;
            if (vld2) begin
                sample_out <= signed_val;
            end
        end
    end

endmodule

// File: tb/tb_sin_nco.sv
// tb/tb_sin_nco.sv - scoreboard bench for sin_nco with behavioural quarter-wave table
module tb_sin_nco;

    localparam int PW = 16;
    localparam int AW = 8;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 phase_clr = 1'b0;
    logic [PW-1:0]        phase_inc = '0;
    logic                 tbl_rd;
    logic [AW-1:0]        tbl_addr;
    logic [DW-1:0]        tbl_data = '0;
    logic signed [DW:0]   sample_out;
    logic                 sample_valid;

    int tbl [256];
    int checks = 0;
    int errors = 0;
    int sb [$];

    logic [PW-1:0] m_phase = '0;
    logic          m_rd = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_v1 = 1'b0;
    logic          m_v2 = 1'b0;

    sin_nco #(
        .PHASE_WIDTH (PW),
        .ADR_WIDTH   (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .phase_clr    (phase_clr),
        .phase_inc    (phase_inc),
        .tbl_rd       (tbl_rd),
        .tbl_addr     (tbl_addr),
        .tbl_data     (tbl_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    // Behavioural quarter-wave table: registered read, one cycle latency.
    always @(posedge clk) begin
        if (tbl_rd) tbl_data <= 8'(tbl[tbl_addr]);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_fold(input logic [PW-1:0] p);
        logic [AW-1:0] i;
        i = p[PW-3 -: AW];
        return p[PW-2] ? ~i : i;
    endfunction

    function automatic int m_sample(input logic [PW-1:0] p);
        int m;
        m = tbl[m_fold(p)];
        return p[PW-1] ? -m : m;
    endfunction

    // Reference model: expected strobes/addresses and scoreboard pushes on every issue.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = '0;
            m_rd    = 1'b0;
            m_addr  = '0;
            m_v1    = 1'b0;
            m_v2    = 1'b0;
            sb.delete();
        end else begin
            m_v2 = m_v1;
            m_v1 = m_rd;
            if (phase_clr) begin
                m_phase = '0;
                m_rd    = 1'b0;
            end else if (en) begin
                m_rd   = 1'b1;
                m_addr = m_fold(m_phase);
                sb.push_back(m_sample(m_phase));
                m_phase = m_phase + phase_inc;
            end else begin
                m_rd = 1'b0;
            end
        end
    end

    // Monitor: compare strobes every cycle, pop the scoreboard on each output sample.
    always @(negedge clk) begin
        int e;
        chk("tbl_rd", int'(tbl_rd), int'(m_rd));
        if (m_rd) chk("tbl_addr", int'(tbl_addr), int'(m_addr));
        chk("sample_valid", int'(sample_valid), int'(m_v2));
        if (sample_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sample_out", int'(sample_out), e);
            end
        end
    end

    int hop_a [4] = '{0, 255, 0, 255};
    int hop_s [4] = '{0, 255, 0, -255};
    int gap   [7] = '{1, 1, 0, 1, 0, 0, 1};

    initial begin
        int next_addr;
        int wrap_a [3];
        int wrap_s [3];
        for (int a = 0; a < 256; a++) begin
            tbl[a] = $rtoi(255.0 * $sin(3.14159265358979 / 2.0 * real'(a) / 255.0) + 0.5);
        end
        wrap_a = '{0, 0, 1};
        wrap_s = '{0, 0, -tbl[1]};

        // Reset held for 3 clocks with en high.
        rst_n = 1'b0; en = 1'b1; phase_inc = 16'h0040;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tbl_rd", int'(tbl_rd), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_sample_out", int'(sample_out), 0);
        rst_n = 1'b1;

        // Sweep: 1024 reads at idx step 1.
        @(posedge clk);
        @(negedge clk);
        chk("first_addr", int'(tbl_addr), 0);
        chk("first_rd", int'(tbl_rd), 1);
        @(posedge clk);
        @(negedge clk);
        chk("sweep_valid_e2", int'(sample_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk("sweep_valid_e3", int'(sample_valid), 1);
        chk("sweep_first_sample", int'(sample_out), 0);
        repeat (1021) @(posedge clk);
        @(negedge clk);

        // Quadrant hop.
        phase_inc = 16'h4000;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hop_addr", int'(tbl_addr), hop_a[(k - 1) % 4]);
            if (k >= 3) chk("hop_sample", int'(sample_out), hop_s[k - 3]);
        end
        en = 1'b0; phase_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        phase_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Gapped enable pattern.
        phase_inc = 16'h0040;
        next_addr = 0;
        for (int i = 0; i < 7; i++) begin
            en = gap[i][0];
            @(posedge clk);
            @(negedge clk);
            if (tbl_rd) begin
                chk("gap_addr", int'(tbl_addr), next_addr);
                next_addr++;
            end
        end
        en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("gap_reads", next_addr, 4);

        // phase_clr mid-stream at phase 16'h3000.
        phase_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        phase_clr = 1'b0; en = 1'b1; phase_inc = 16'h1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        phase_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("clr_tbl_rd", int'(tbl_rd), 0);
        phase_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("clr_next_addr", int'(tbl_addr), 0);
        chk("clr_next_rd", int'(tbl_rd), 1);
        en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        // Wrap into negative phase.
        phase_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        phase_clr = 1'b0; en = 1'b1; phase_inc = 16'hFFC0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 3) chk("wrap_addr", int'(tbl_addr), wrap_a[k - 1]);
            if (k >= 3) chk("wrap_sample", int'(sample_out), wrap_s[k - 3]);
        end

        // Reset mid-stream: pipe is discarded.
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_rd", int'(tbl_rd), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
